// File: rtl/mem_writeback_buffer_pkg.sv
// mem_writeback_buffer_pkg: shared bus command type, buffer entry layout and default depth.
//   BUS_COMMAND : memory bus request encoding
//   WB_ENTRY    : one buffered line {valid, line address [31:3], 64-bit data}
//   WB_DEPTH    : default number of buffered lines
package mem_writeback_buffer_pkg;
    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } BUS_COMMAND;

    typedef struct packed {
        logic        valid;
        logic [28:0] addr;
        logic [63:0] data;
    } WB_ENTRY;

    localparam int WB_DEPTH = 4;
endpackage

// File: rtl/mem_writeback_buffer_wb_fifo.sv
// wb_fifo: circular line buffer with head/tail/count and a parallel address lookup.
//   clock, reset      : rising-edge clock, asynchronous active-low reset
//   push/push_addr/push_data : append an entry at the tail
//   pop               : retire the head entry
//   wr_en/wr_idx/wr_data     : overwrite the data of an existing entry in place
//   lookup_addr       : line address compared against every valid entry
//   head_entry/head_idx      : oldest entry and its slot
//   count             : number of valid entries
//   match_vec/match_idx      : per-slot match flags and the slot of a match
module wb_fifo
    import mem_writeback_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [28:0]      push_addr,
    input  logic [63:0]      push_data,
    input  logic             pop,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_idx,
    input  logic [63:0]      wr_data,
    input  logic [28:0]      lookup_addr,
    output WB_ENTRY          head_entry,
    output logic [PW-1:0]    head_idx,
    output logic [CW-1:0]    count,
    output logic [DEPTH-1:0] match_vec,
    output logic [PW-1:0]    match_idx
);
    WB_ENTRY mem [DEPTH];
    logic [PW-1:0] head, tail;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) begin
                mem[head].valid <= 1'b0;
                head            <= head + 1'b1;
            end
            if (push) begin
                mem[tail] <= '{valid: 1'b1, addr: push_addr, data: push_data};
                tail      <= tail + 1'b1;
            end
            if (wr_en) mem[wr_idx].data <= wr_data;
            count <= count + CW'(push) - CW'(pop);
        end

    // Coalescing keeps at most one entry per line, so a single index suffices.
    always_comb begin
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = mem[i].valid && mem[i].addr == lookup_addr;
            if (match_vec[i]) match_idx = PW'(i);
        end
    end

    assign head_entry = mem[head];
    assign head_idx   = head;
endmodule

// File: rtl/mem_writeback_buffer.sv
// mem_writeback_buffer: posted-store buffer between the cache arbiter and main memory.
//   clock, reset              : rising-edge clock, asynchronous active-low reset
//   cache2buf_*               : cache request (addr, command, store data)
//   buf2cache_response        : nonzero when the cache request is accepted this cycle
//   buf2cache_tag/data        : memory load return, passed straight through
//   buf2mem_*                 : memory request (addr, command, store data)
//   mem2buf_response/tag/data : memory accept tag (0 = rejected) and load return
//   drain_all                 : stop accepting stores and flush the buffer
//   wb_empty, wb_count        : buffer occupancy
module mem_writeback_buffer
    import mem_writeback_buffer_pkg::*;
#(
    parameter int         DEPTH         = WB_DEPTH,
    parameter logic [3:0] STORE_ACK_TAG = 4'hF,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [31:0]   cache2buf_addr,
    input  BUS_COMMAND    cache2buf_command,
    input  logic [63:0]   cache2buf_data,
    output logic [3:0]    buf2cache_response,
    output logic [3:0]    buf2cache_tag,
    output logic [63:0]   buf2cache_data,
    output logic [31:0]   buf2mem_addr,
    output BUS_COMMAND    buf2mem_command,
    output logic [63:0]   buf2mem_data,
    input  logic [3:0]    mem2buf_response,
    input  logic [3:0]    mem2buf_tag,
    input  logic [63:0]   mem2buf_data,
    input  logic          drain_all,
    output logic          wb_empty,
    output logic [CW-1:0] wb_count
);
    WB_ENTRY          head_entry;
    logic [PW-1:0]    head_idx, match_idx;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] match_vec;
    logic is_load, is_store, match_any, full, drain, fwd, issue, pop, coalesce, push;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .push_addr   (cache2buf_addr[31:3]),
        .push_data   (cache2buf_data),
        .pop         (pop),
        .wr_en       (coalesce),
        .wr_idx      (match_idx),
        .wr_data     (cache2buf_data),
        .lookup_addr (cache2buf_addr[31:3]),
        .head_entry  (head_entry),
        .head_idx    (head_idx),
        .count       (count),
        .match_vec   (match_vec),
        .match_idx   (match_idx)
    );

    always_comb begin
        is_load   = cache2buf_command == BUS_LOAD;
        is_store  = cache2buf_command == BUS_STORE;
        match_any = |match_vec;
        full      = count == CW'(DEPTH);
        drain     = full || drain_all || (is_load && match_any);
        fwd       = is_load && !drain;
        issue     = head_entry.valid && !fwd;
        pop       = issue && |mem2buf_response;
        // A match on the head that leaves this cycle cannot absorb the store; it is pushed fresh.
        coalesce  = is_store && !drain_all && match_any && !(pop && match_idx == head_idx);
        push      = is_store && !drain_all && !coalesce && !full;
        buf2mem_command    = fwd ? BUS_LOAD : issue ? BUS_STORE : BUS_NONE;
        buf2mem_addr       = fwd ? cache2buf_addr : issue ? {head_entry.addr, 3'b000} : 32'h0;
        buf2mem_data       = fwd ? cache2buf_data : issue ? head_entry.data : 64'h0;
        buf2cache_response = fwd ? mem2buf_response : (coalesce || push) ? STORE_ACK_TAG : 4'h0;
    end

    assign buf2cache_tag  = mem2buf_tag;
    assign buf2cache_data = mem2buf_data;
    assign wb_count       = count;
    assign wb_empty       = count == '0;
endmodule

// File: tb/tb_mem_writeback_buffer.sv
// tb_mem_writeback_buffer: directed and random checks of mem_writeback_buffer against a queue model.
module tb_mem_writeback_buffer;
    import mem_writeback_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clock, reset;
    logic [31:0] cache2buf_addr;
    BUS_COMMAND  cache2buf_command;
    logic [63:0] cache2buf_data;
    logic [3:0]  buf2cache_response, buf2cache_tag;
    logic [63:0] buf2cache_data;
    logic [31:0] buf2mem_addr;
    BUS_COMMAND  buf2mem_command;
    logic [63:0] buf2mem_data;
    logic [3:0]  mem2buf_response, mem2buf_tag;
    logic [63:0] mem2buf_data;
    logic        drain_all, wb_empty;
    logic [2:0]  wb_count;

    mem_writeback_buffer #(.DEPTH(DEPTH), .STORE_ACK_TAG(4'hF)) dut (
        .clock(clock), .reset(reset),
        .cache2buf_addr(cache2buf_addr), .cache2buf_command(cache2buf_command),
        .cache2buf_data(cache2buf_data),
        .buf2cache_response(buf2cache_response), .buf2cache_tag(buf2cache_tag),
        .buf2cache_data(buf2cache_data),
        .buf2mem_addr(buf2mem_addr), .buf2mem_command(buf2mem_command),
        .buf2mem_data(buf2mem_data),
        .mem2buf_response(mem2buf_response), .mem2buf_tag(mem2buf_tag),
        .mem2buf_data(mem2buf_data),
        .drain_all(drain_all), .wb_empty(wb_empty), .wb_count(wb_count)
    );

    typedef struct {
        logic [28:0] addr;
        logic [63:0] data;
    } ent_t;

    ent_t q[$];
    int checks = 0, failures = 0;
    logic [3:0]  o_resp;
    BUS_COMMAND  o_cmd;
    logic [31:0] o_addr;
    logic [63:0] o_data;
    logic [2:0]  o_count;
    logic        o_empty;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        cache2buf_command = BUS_NONE;
        cache2buf_addr    = '0;
        cache2buf_data    = '0;
        mem2buf_response  = '0;
        mem2buf_tag       = '0;
        mem2buf_data      = '0;
        drain_all         = 1'b0;
    endtask

    // Asynchronous reset pulse between edges; the model simply forgets everything.
    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        idle_inputs();
        q.delete();
        #1;
        chk("rst_empty", 64'(wb_empty), 64'd1);
        chk("rst_count", 64'(wb_count), 64'd0);
        chk("rst_cmd", 64'(buf2mem_command), 64'(BUS_NONE));
        chk("rst_resp", 64'(buf2cache_response), 64'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One cycle: drive, compare against the model, then advance the model to the next edge.
    task automatic step(input BUS_COMMAND c, input logic [31:0] a, input logic [63:0] d,
                        input logic [3:0] r, input logic dr);
        int m;
        logic ld, st, drn, fwd, si, pop, co, pu;
        logic [3:0]  e_resp;
        BUS_COMMAND  e_cmd;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        @(negedge clock);
        cache2buf_command = c;
        cache2buf_addr    = a;
        cache2buf_data    = d;
        mem2buf_response  = r;
        drain_all         = dr;
        mem2buf_tag       = 4'($urandom);
        mem2buf_data      = {$urandom, $urandom};
        #1;
        m = -1;
        foreach (q[i]) if (q[i].addr == a[31:3]) m = i;
        ld  = c == BUS_LOAD;
        st  = c == BUS_STORE;
        drn = q.size() == DEPTH || dr || (ld && m >= 0);
        fwd = ld && !drn;
        si  = q.size() > 0 && !fwd;
        pop = si && r != 0;
        co  = st && !dr && m >= 0 && !(pop && m == 0);
        pu  = st && !dr && !co && q.size() < DEPTH;
        e_cmd  = fwd ? BUS_LOAD : si ? BUS_STORE : BUS_NONE;
        e_addr = fwd ? a : si ? {q[0].addr, 3'b000} : 32'h0;
        e_data = fwd ? d : si ? q[0].data : 64'h0;
        e_resp = fwd ? r : (co || pu) ? 4'hF : 4'h0;
        o_resp = buf2cache_response; o_cmd = buf2mem_command; o_addr = buf2mem_addr;
        o_data = buf2mem_data; o_count = wb_count; o_empty = wb_empty;
        chk("response", 64'(o_resp), 64'(e_resp));
        chk("mem_cmd", 64'(o_cmd), 64'(e_cmd));
        chk("mem_addr", 64'(o_addr), 64'(e_addr));
        chk("mem_data", o_data, e_data);
        chk("wb_count", 64'(o_count), 64'(q.size()));
        chk("wb_empty", 64'(o_empty), 64'(q.size() == 0));
        chk("pass_tag", 64'(buf2cache_tag), 64'(mem2buf_tag));
        chk("pass_data", buf2cache_data, mem2buf_data);
        if (co) q[m].data = d;
        if (pop) void'(q.pop_front());
        if (pu) q.push_back('{addr: a[31:3], data: d});
    endtask

    initial begin
        int n;
        idle_inputs();
        reset = 1'b0;
        #12;
        chk("init_empty", 64'(wb_empty), 64'd1);
        chk("init_count", 64'(wb_count), 64'd0);
        chk("init_cmd", 64'(buf2mem_command), 64'(BUS_NONE));
        chk("init_resp", 64'(buf2cache_response), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Posted store drains on the next idle cycle.
        step(BUS_STORE, 32'h1000, 64'hAAAA, 4'd3, 1'b0);
        chk("t1_ack", 64'(o_resp), 64'hF);
        chk("t1_cmd0", 64'(o_cmd), 64'(BUS_NONE));
        step(BUS_NONE, 32'h0, 64'h0, 4'd3, 1'b0);
        chk("t1_cmd1", 64'(o_cmd), 64'(BUS_STORE));
        chk("t1_addr1", 64'(o_addr), 64'h1000);
        chk("t1_data1", o_data, 64'hAAAA);
        step(BUS_NONE, 32'h0, 64'h0, 4'd0, 1'b0);
        chk("t1_empty", 64'(o_empty), 64'd1);

        // Load bypasses a buffered store.
        step(BUS_STORE, 32'h2000, 64'h2222, 4'd0, 1'b0);
        step(BUS_LOAD, 32'h3000, 64'h0, 4'd5, 1'b0);
        chk("t2_resp", 64'(o_resp), 64'd5);
        chk("t2_cmd", 64'(o_cmd), 64'(BUS_LOAD));
        chk("t2_addr", 64'(o_addr), 64'h3000);
        step(BUS_NONE, 32'h0, 64'h0, 4'd0, 1'b0);
        chk("t2_count", 64'(o_count), 64'd1);

        // Same-line load is held until the store is accepted.
        step(BUS_LOAD, 32'h2004, 64'h0, 4'd0, 1'b0);
        chk("t3_hold0", 64'(o_resp), 64'd0);
        chk("t3_st_addr", 64'(o_addr), 64'h2000);
        step(BUS_LOAD, 32'h2004, 64'h0, 4'd7, 1'b0);
        chk("t3_hold1", 64'(o_resp), 64'd0);
        chk("t3_st_cmd", 64'(o_cmd), 64'(BUS_STORE));
        step(BUS_LOAD, 32'h2004, 64'h0, 4'd7, 1'b0);
        chk("t3_fwd", 64'(o_resp), 64'd7);
        chk("t3_fwd_addr", 64'(o_addr), 64'h2004);

        // Full buffer refuses stores and holds loads; no pop-then-push bypass.
        for (int i = 0; i < 4; i++) step(BUS_STORE, 32'h5000 + 32'(i * 8), 64'(i), 4'd0, 1'b0);
        step(BUS_STORE, 32'h6000, 64'h66, 4'd0, 1'b0);
        chk("t4_full_resp", 64'(o_resp), 64'd0);
        chk("t4_full_count", 64'(o_count), 64'd4);
        step(BUS_LOAD, 32'h7000, 64'h0, 4'd0, 1'b0);
        chk("t4_load_held", 64'(o_resp), 64'd0);
        step(BUS_STORE, 32'h6000, 64'h66, 4'd2, 1'b0);
        chk("t4_no_bypass", 64'(o_resp), 64'd0);
        chk("t4_pop_addr", 64'(o_addr), 64'h5000);
        step(BUS_STORE, 32'h6000, 64'h66, 4'd0, 1'b0);
        chk("t4_accept", 64'(o_resp), 64'hF);
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step(BUS_NONE, 32'h0, 64'h0, 4'd1, 1'b0);
            n++;
        end
        step(BUS_NONE, 32'h0, 64'h0, 4'd0, 1'b0);
        chk("t4_drained", 64'(o_empty), 64'd1);

        // Coalescing: newest data wins, count stays 1.
        step(BUS_STORE, 32'h4000, 64'd1, 4'd0, 1'b0);
        step(BUS_STORE, 32'h4000, 64'd2, 4'd0, 1'b0);
        chk("t5_ack", 64'(o_resp), 64'hF);
        step(BUS_NONE, 32'h0, 64'h0, 4'd1, 1'b0);
        chk("t5_count", 64'(o_count), 64'd1);
        chk("t5_data", o_data, 64'd2);

        // drain_all interrupted by reset discards remaining entries.
        for (int i = 0; i < 3; i++) step(BUS_STORE, 32'h8000 + 32'(i * 8), 64'(i + 10), 4'd0, 1'b0);
        step(BUS_STORE, 32'h9000, 64'h9, 4'd1, 1'b1);
        chk("t6_no_accept", 64'(o_resp), 64'd0);
        chk("t6_pop_addr", 64'(o_addr), 64'h8000);
        do_reset();
        step(BUS_NONE, 32'h0, 64'h0, 4'd1, 1'b1);
        chk("t6_no_store", 64'(o_cmd), 64'(BUS_NONE));
        chk("t6_empty", 64'(o_empty), 64'd1);

        // Random traffic over a small set of lines to provoke matches, hazards and coalescing.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(BUS_COMMAND'($urandom_range(0, 2)),
                      32'h9000 + 32'($urandom_range(0, 5) * 8) + 32'($urandom_range(0, 7)),
                      {$urandom, $urandom},
                      ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(1, 15)),
                      $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
